// File: rtl/ftdi_cmd_encoder.sv
// Host-side initiator for the FTDI bridge byte protocol: serialises requests into
// cmd/len/addr/data bytes and reassembles the bridge's response bytes.
module ftdi_cmd_encoder #(
  parameter bit LITTLE_ENDIAN = 1'b1,
  parameter int GP_W          = 8,
  parameter int RESP_TIMEOUT  = 65535
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      req_cmd_i,
  input  logic [11:0]     req_len_i,
  input  logic [31:0]     req_addr_i,
  input  logic [GP_W-1:0] req_gp_i,
  input  logic [31:0]     wdata_i,
  input  logic            wdata_valid_i,
  output logic            wdata_ready_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_accept_i,
  output logic            rx_rd_o,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_ready_i,
  output logic [31:0]     rdata_o,
  output logic            rdata_valid_o,
  output logic [GP_W-1:0] gp_rdata_o,
  output logic            gp_valid_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam logic [3:0] S_IDLE = 4'd0, S_CMD = 4'd1, S_LEN = 4'd2,
                         S_ADDR0 = 4'd3, S_ADDR1 = 4'd4, S_ADDR2 = 4'd5, S_ADDR3 = 4'd6,
                         S_WDATA = 4'd7, S_RDATA = 4'd8, S_GP_VAL = 4'd9, S_GP_RESP = 4'd10;

  localparam logic [3:0] C_NOP = 4'd0, C_WR = 4'd1, C_RD = 4'd2, C_GPWR = 4'd3, C_GPRD = 4'd4;

  localparam logic [16:0] TO_LIM = 17'(RESP_TIMEOUT);
  localparam bit          TO_EN  = (RESP_TIMEOUT != 0);

  typedef struct packed {
    logic [3:0]  cmd;
    logic [11:0] len;
    logic [31:0] addr;
    logic [7:0]  gp;
  } req_t;

  logic [3:0]  state;
  req_t        cur;
  logic [11:0] rem;
  logic [1:0]  lane;
  logic        need_word;
  logic [31:0] wword;
  logic [10:0] words_rem;
  logic [1:0]  byte_idx;
  logic [31:0] shreg;
  logic [16:0] to_cnt;

  logic [7:0]  cmd_byte, gp_byte;
  logic        is_wrrd, bad_req;
  logic [31:0] rx_word;
  logic [10:0] rd_words;

  // Lane k of a write word, honouring the bridge byte order.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] k);
    if (LITTLE_ENDIAN) return w[{k, 3'b000} +: 8];
    else               return w[{~k, 3'b000} +: 8];
  endfunction

  assign is_wrrd  = (req_cmd_i == C_WR) || (req_cmd_i == C_RD);
  assign bad_req  = (req_cmd_i > C_GPRD) || (is_wrrd && (req_len_i == 12'd0));
  assign cmd_byte = is_wrrd ? {req_len_i[11:8], req_cmd_i} : {4'h0, req_cmd_i};
  // Reads always return whole words regardless of the address low bits.
  assign rd_words = {1'b0, cur.len[11:2]} + {10'b0, |cur.len[1:0]};

  always_comb begin
    gp_byte = '0;
    gp_byte[GP_W-1:0] = req_gp_i;
  end

  always_comb begin
    rx_word = shreg;
    if (LITTLE_ENDIAN) rx_word[{byte_idx, 3'b000} +: 8] = rx_data_i;
    else               rx_word[{~byte_idx, 3'b000} +: 8] = rx_data_i;
  end

  assign req_ready_o   = (state == S_IDLE);
  assign busy_o        = (state != S_IDLE);
  assign rx_rd_o       = (state == S_RDATA) || (state == S_GP_RESP);
  assign wdata_ready_o = (state == S_WDATA) && need_word && wdata_valid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      cur           <= '0;
      rem           <= '0;
      lane          <= '0;
      need_word     <= 1'b0;
      wword         <= '0;
      words_rem     <= '0;
      byte_idx      <= '0;
      shreg         <= '0;
      to_cnt        <= '0;
      tx_data_o     <= '0;
      tx_valid_o    <= 1'b0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      gp_rdata_o    <= '0;
      gp_valid_o    <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      err_o         <= 1'b0;
      rdata_valid_o <= 1'b0;
      gp_valid_o    <= 1'b0;
      case (state)
        S_IDLE: if (req_valid_i) begin
          if (bad_req) err_o <= 1'b1;
          else begin
            cur        <= '{cmd: req_cmd_i, len: req_len_i, addr: req_addr_i, gp: gp_byte};
            tx_data_o  <= cmd_byte;
            tx_valid_o <= 1'b1;
            state      <= S_CMD;
          end
        end
        S_CMD: if (tx_accept_i) begin
          case (cur.cmd)
            C_WR, C_RD: begin state <= S_LEN;     tx_data_o  <= cur.len[7:0]; end
            C_GPWR:     begin state <= S_GP_VAL;  tx_data_o  <= cur.gp;       end
            C_GPRD:     begin state <= S_GP_RESP; tx_valid_o <= 1'b0; to_cnt <= '0; end
            default:    begin state <= S_IDLE;    tx_valid_o <= 1'b0;         end
          endcase
        end
        S_LEN:   if (tx_accept_i) begin state <= S_ADDR0; tx_data_o <= cur.addr[31:24]; end
        S_ADDR0: if (tx_accept_i) begin state <= S_ADDR1; tx_data_o <= cur.addr[23:16]; end
        S_ADDR1: if (tx_accept_i) begin state <= S_ADDR2; tx_data_o <= cur.addr[15:8];  end
        S_ADDR2: if (tx_accept_i) begin state <= S_ADDR3; tx_data_o <= cur.addr[7:0];   end
        S_ADDR3: if (tx_accept_i) begin
          tx_valid_o <= 1'b0;
          rem        <= cur.len;
          lane       <= cur.addr[1:0];
          need_word  <= 1'b1;
          words_rem  <= rd_words;
          byte_idx   <= '0;
          to_cnt     <= '0;
          state      <= (cur.cmd == C_WR) ? S_WDATA : S_RDATA;
        end
        S_WDATA: begin
          if (need_word) begin
            if (wdata_valid_i) begin
              wword      <= wdata_i;
              need_word  <= 1'b0;
              tx_data_o  <= lane_byte(wdata_i, lane);
              tx_valid_o <= 1'b1;
            end
          end else if (tx_accept_i) begin
            rem  <= rem - 12'd1;
            lane <= lane + 2'd1;
            if (rem == 12'd1) begin
              state      <= S_IDLE;
              tx_valid_o <= 1'b0;
            end else if (lane == 2'd3) begin
              need_word  <= 1'b1;
              tx_valid_o <= 1'b0;
            end else begin
              tx_data_o <= lane_byte(wword, lane + 2'd1);
            end
          end
        end
        S_RDATA: begin
          if (rx_ready_i) begin
            to_cnt   <= '0;
            byte_idx <= byte_idx + 2'd1;
            shreg    <= rx_word;
            if (byte_idx == 2'd3) begin
              rdata_o       <= rx_word;
              rdata_valid_o <= 1'b1;
              words_rem     <= words_rem - 11'd1;
              if (words_rem == 11'd1) state <= S_IDLE;
            end
          end else if (TO_EN && (to_cnt + 17'd1 == TO_LIM)) begin
            // Partial word in shreg is simply abandoned.
            err_o <= 1'b1;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 17'd1;
          end
        end
        S_GP_VAL: if (tx_accept_i) begin
          state      <= S_IDLE;
          tx_valid_o <= 1'b0;
        end
        S_GP_RESP: begin
          if (rx_ready_i) begin
            gp_rdata_o <= rx_data_i[GP_W-1:0];
            gp_valid_o <= 1'b1;
            state      <= S_IDLE;
          end else if (TO_EN && (to_cnt + 17'd1 == TO_LIM)) begin
            err_o <= 1'b1;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 17'd1;
          end
        end
        default: begin
          state      <= S_IDLE;
          tx_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_cmd_encoder.sv
// Bench for ftdi_cmd_encoder: byte-stream scoreboard plus directed literal checks,
// with a little- and a big-endian instance fed the same stimulus.
module tb_ftdi_cmd_encoder;
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, wdata_valid, tx_accept, rx_ready;
  logic [3:0]  req_cmd;
  logic [11:0] req_len;
  logic [31:0] req_addr, wdata;
  logic [7:0]  req_gp, rx_data;

  logic        req_ready, wdata_ready, tx_valid, rx_rd, rdata_valid, gp_valid, err, busy;
  logic [7:0]  tx_data, gp_rdata;
  logic [31:0] rdata;
  logic        req_ready_b, wdata_ready_b, tx_valid_b, rx_rd_b, rdata_valid_b, gp_valid_b, err_b, busy_b;
  logic [7:0]  tx_data_b, gp_rdata_b;
  logic [31:0] rdata_b;

  ftdi_cmd_encoder #(.LITTLE_ENDIAN(1'b1), .GP_W(8), .RESP_TIMEOUT(16)) u_le (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_cmd_i(req_cmd), .req_len_i(req_len), .req_addr_i(req_addr), .req_gp_i(req_gp),
    .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_accept_i(tx_accept),
    .rx_rd_o(rx_rd), .rx_data_i(rx_data), .rx_ready_i(rx_ready),
    .rdata_o(rdata), .rdata_valid_o(rdata_valid), .gp_rdata_o(gp_rdata),
    .gp_valid_o(gp_valid), .err_o(err), .busy_o(busy));

  ftdi_cmd_encoder #(.LITTLE_ENDIAN(1'b0), .GP_W(8), .RESP_TIMEOUT(16)) u_be (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_b),
    .req_cmd_i(req_cmd), .req_len_i(req_len), .req_addr_i(req_addr), .req_gp_i(req_gp),
    .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready_b),
    .tx_data_o(tx_data_b), .tx_valid_o(tx_valid_b), .tx_accept_i(tx_accept),
    .rx_rd_o(rx_rd_b), .rx_data_i(rx_data), .rx_ready_i(rx_ready),
    .rdata_o(rdata_b), .rdata_valid_o(rdata_valid_b), .gp_rdata_o(gp_rdata_b),
    .gp_valid_o(gp_valid_b), .err_o(err_b), .busy_o(busy_b));

  int n_chk = 0, n_pass = 0;
  int cyc = 0, wpulses = 0, rd_cnt = 0, gp_cnt = 0, err_cnt = 0, err_cyc = 0;
  int err_allow = 0, n_stall = 0, last_cyc = 0;
  bit stall = 0, free_tx = 0;
  logic [7:0]  exp_tx[$], txlog[$], rxb[$], exp_gp[$];
  logic [31:0] exp_le[$], exp_be[$], rdlog[$], rdlog_b[$], wq[$], mwords[$];
  logic        prev_v, prev_acc;
  logic [7:0]  prev_d;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
  endtask

  // Model: the byte stream a request must produce, from the protocol rules.
  task automatic model_req(input logic [3:0] cmd, input logic [11:0] len,
                           input logic [31:0] addr, input logic [7:0] gp);
    logic [31:0] w;
    int idx;
    exp_tx.push_back((cmd == 4'd1 || cmd == 4'd2) ? {len[11:8], cmd} : {4'h0, cmd});
    if (cmd == 4'd1 || cmd == 4'd2) begin
      exp_tx.push_back(len[7:0]);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(addr[8*i +: 8]);
    end
    if (cmd == 4'd1)
      for (int i = 0; i < int'(len); i++) begin
        idx = int'(addr[1:0]) + i;
        w = mwords[idx / 4];
        exp_tx.push_back(w[8*(idx % 4) +: 8]);
      end
    if (cmd == 4'd3) exp_tx.push_back(gp);
  endtask

  // Model: words a read returns from the rx bytes; incomplete words never appear.
  task automatic model_rd(input int len);
    for (int w = 0; w < (len + 3) / 4; w++)
      if (4*w + 3 < rxb.size()) begin
        exp_le.push_back({rxb[4*w+3], rxb[4*w+2], rxb[4*w+1], rxb[4*w]});
        exp_be.push_back({rxb[4*w], rxb[4*w+1], rxb[4*w+2], rxb[4*w+3]});
      end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    tx_accept   = stall ? ((cyc % 3) != 1) && ($urandom_range(0, 4) != 0) : 1'b1;
    wdata_valid = (wq.size() != 0);
    wdata       = (wq.size() != 0) ? wq[0] : 32'h0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0; prev_acc = 1'b0; prev_d = 8'h0;
    end else begin
      if (prev_v && !prev_acc) begin
        chk("tx_valid_hold", tx_valid, 1);
        chk("tx_data_hold", tx_data, prev_d);
      end
      if (tx_valid && !tx_accept) n_stall++;
      if (tx_valid && tx_accept) begin
        txlog.push_back(tx_data);
        if (!free_tx) begin
          chk("tx_expected", exp_tx.size() != 0, 1);
          if (exp_tx.size() != 0) chk("tx_byte", tx_data, exp_tx.pop_front());
        end
      end
      prev_v = tx_valid; prev_acc = tx_accept; prev_d = tx_data;
      if (wdata_ready) begin
        wpulses++;
        chk("wdata_ready_valid", wdata_valid, 1);
        if (wq.size() != 0) void'(wq.pop_front());
      end
      if (rdata_valid) begin
        rd_cnt++;
        rdlog.push_back(rdata);
        chk("rd_expected", exp_le.size() != 0, 1);
        if (exp_le.size() != 0) chk("rdata_le", rdata, exp_le.pop_front());
      end
      if (rdata_valid_b) begin
        rdlog_b.push_back(rdata_b);
        chk("rd_expected_be", exp_be.size() != 0, 1);
        if (exp_be.size() != 0) chk("rdata_be", rdata_b, exp_be.pop_front());
      end
      if (gp_valid) begin
        gp_cnt++;
        chk("gp_expected", exp_gp.size() != 0, 1);
        if (exp_gp.size() != 0) chk("gp_rdata", gp_rdata, exp_gp.pop_front());
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
        chk("err_expected", err_allow > 0, 1);
        if (err_allow > 0) err_allow--;
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) return;
    end
    chk({name, "_idle_timeout"}, req_ready, 1);
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [11:0] len,
                       input logic [31:0] addr, input logic [7:0] gp);
    @(posedge clk); #1;
    req_valid = 1'b1; req_cmd = cmd; req_len = len; req_addr = addr; req_gp = gp;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_rx(input int n);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_rd) break;
    end
    chk("rx_rd_wait", rx_rd, 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rx_ready = 1'b1; rx_data = rxb[k]; last_cyc = cyc;
      @(posedge clk); #1;
      rx_ready = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  wr1 [12];
    logic [7:0]  wr2 [9];
    logic [7:0]  rdtx [6];
    int nb, w0, r0, e0, g0;
    wr1  = '{8'h01, 8'h06, 8'h00, 8'h00, 8'h10, 8'h02, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    wr2  = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h01, 8'h03, 8'hDD, 8'h11, 8'h22};
    rdtx = '{8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h20};
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_len = '0; req_addr = '0; req_gp = '0;
    rx_ready = 1'b0; rx_data = '0; tx_accept = 1'b1; wdata = '0; wdata_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_rd", rx_rd, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_gp_rdata", gp_rdata, 0);
    chk("rst_gp_valid", gp_valid, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // GP_WR 0xA5
    txlog.delete();
    model_req(4'd3, 12'd0, 32'h0, 8'hA5);
    issue(4'd3, 12'd0, 32'h0, 8'hA5);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    chk("gpwr_busy_cycles_2to3", (nb >= 2) && (nb <= 3), 1);
    chk("gpwr_ready_after", req_ready, 1);
    settle();
    chk("gpwr_nbytes", txlog.size(), 2);
    if (txlog.size() == 2) begin
      chk("gpwr_b0", txlog[0], 8'h03);
      chk("gpwr_b1", txlog[1], 8'hA5);
    end

    // WR len=6 addr=0x1002
    txlog.delete(); mwords.delete();
    mwords.push_back(32'h44332211); mwords.push_back(32'h88776655);
    wq.push_back(32'h44332211); wq.push_back(32'h88776655);
    w0 = wpulses;
    model_req(4'd1, 12'd6, 32'h00001002, 8'h0);
    issue(4'd1, 12'd6, 32'h00001002, 8'h0);
    wait_idle("wr6");
    settle();
    chk("wr6_nbytes", txlog.size(), 12);
    for (int i = 0; i < 12; i++) if (i < txlog.size()) chk("wr6_byte", txlog[i], wr1[i]);
    chk("wr6_word_pulses", wpulses - w0, 2);

    // RD len=5 addr=0x20
    txlog.delete(); rdlog.delete(); rdlog_b.delete(); rxb.delete();
    for (int i = 1; i <= 8; i++) rxb.push_back(8'(i));
    r0 = rd_cnt;
    model_req(4'd2, 12'd5, 32'h20, 8'h0);
    model_rd(5);
    issue(4'd2, 12'd5, 32'h20, 8'h0);
    send_rx(8);
    wait_idle("rd5");
    settle();
    for (int i = 0; i < 6; i++) if (i < txlog.size()) chk("rd5_tx", txlog[i], rdtx[i]);
    chk("rd5_pulses", rd_cnt - r0, 2);
    if (rdlog.size() == 2 && rdlog_b.size() == 2) begin
      chk("rd5_le_w0", rdlog[0], 32'h04030201);
      chk("rd5_le_w1", rdlog[1], 32'h08070605);
      chk("rd5_be_w0", rdlog_b[0], 32'h01020304);
      chk("rd5_be_w1", rdlog_b[1], 32'h05060708);
    end else chk("rd5_log_sizes", rdlog.size() + rdlog_b.size(), 4);

    // GP_RD with link stalls
    stall = 1;
    txlog.delete(); rxb.delete(); rxb.push_back(8'h3C);
    g0 = gp_cnt;
    model_req(4'd4, 12'd0, 32'h0, 8'h0);
    exp_gp.push_back(8'h3C);
    issue(4'd4, 12'd0, 32'h0, 8'h0);
    send_rx(1);
    wait_idle("gprd");
    settle();
    chk("gprd_value", gp_rdata, 8'h3C);
    chk("gprd_pulses", gp_cnt - g0, 1);
    chk("gprd_nbytes", txlog.size(), 1);

    // WR len=3 at lane 3 with stalls: lane wrap, unused lanes dropped
    txlog.delete(); mwords.delete();
    mwords.push_back(32'hDDCCBBAA); mwords.push_back(32'h44332211);
    wq.push_back(32'hDDCCBBAA); wq.push_back(32'h44332211);
    w0 = wpulses;
    model_req(4'd1, 12'd3, 32'h00000103, 8'h0);
    issue(4'd1, 12'd3, 32'h00000103, 8'h0);
    wait_idle("wr3");
    settle();
    stall = 0;
    for (int i = 0; i < 9; i++) if (i < txlog.size()) chk("wr3_byte", txlog[i], wr2[i]);
    chk("wr3_nbytes", txlog.size(), 9);
    chk("wr3_word_pulses", wpulses - w0, 2);
    chk("stall_seen", n_stall > 0, 1);

    // RD len=4 timeout after two bytes
    rxb.delete(); rxb.push_back(8'hAA); rxb.push_back(8'hBB);
    r0 = rd_cnt; e0 = err_cnt; err_allow = 1;
    model_req(4'd2, 12'd4, 32'h0, 8'h0);
    model_rd(4);
    issue(4'd2, 12'd4, 32'h0, 8'h0);
    send_rx(2);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (err_cnt != e0) break;
    end
    chk("to_err_pulses", err_cnt - e0, 1);
    chk("to_delay_15to18", (err_cyc - last_cyc >= 15) && (err_cyc - last_cyc <= 18), 1);
    wait_idle("to");
    chk("to_no_rdata", rd_cnt - r0, 0);
    txlog.delete();
    model_req(4'd0, 12'd0, 32'h0, 8'h0);
    issue(4'd0, 12'd0, 32'h0, 8'h0);
    wait_idle("nop");
    settle();
    chk("nop_nbytes", txlog.size(), 1);
    if (txlog.size() == 1) chk("nop_byte", txlog[0], 8'h00);

    // Bad requests: WR len=0, cmd=0xF
    txlog.delete(); e0 = err_cnt; err_allow = 1;
    issue(4'd1, 12'd0, 32'h40, 8'h0);
    settle();
    chk("badlen_err", err_cnt - e0, 1);
    chk("badlen_no_tx", txlog.size(), 0);
    chk("badlen_ready", req_ready, 1);
    e0 = err_cnt; err_allow = 1;
    issue(4'hF, 12'd4, 32'h40, 8'h0);
    settle();
    chk("badcmd_err", err_cnt - e0, 1);
    chk("badcmd_no_tx", txlog.size(), 0);

    // Reset in the middle of the address bytes
    free_tx = 1; txlog.delete();
    issue(4'd1, 12'd4, 32'h11223344, 8'h0);
    for (int i = 0; i < 50; i++) begin
      if (txlog.size() >= 3) break;
      @(posedge clk); #1;
    end
    chk("mid_reached_addr", txlog.size() >= 3, 1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; free_tx = 0; exp_tx.delete(); wq.delete();

    txlog.delete();
    model_req(4'd3, 12'd0, 32'h0, 8'h5A);
    issue(4'd3, 12'd0, 32'h0, 8'h5A);
    wait_idle("post_rst");
    settle();
    chk("post_rst_nbytes", txlog.size(), 2);
    chk("exp_tx_drained", exp_tx.size(), 0);
    chk("exp_rd_drained", exp_le.size() + exp_be.size() + exp_gp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
